// File: rtl/ysyx_23060025_icache_refill_pkg.sv
// Shared AXI/cache-line constants for the icache refill path.
//   SIZE_*     : AXI AxSIZE encodings (bytes per beat)
//   axi_size() : AxSIZE encoding for a beat width in bits
package ysyx_23060025_icache_refill_pkg;

  localparam logic [2:0] SIZE_1B = 3'b000;
  localparam logic [2:0] SIZE_2B = 3'b001;
  localparam logic [2:0] SIZE_4B = 3'b010;
  localparam logic [2:0] SIZE_8B = 3'b011;

  localparam int ICACHE_ADDR_LEN   = 32;
  localparam int ICACHE_DATA_LEN   = 32;
  localparam int ICACHE_LINE_BEATS = 4;

  function automatic logic [2:0] axi_size(input int data_len);
    return 3'($clog2(data_len / 8));
  endfunction

endpackage

// File: rtl/ysyx_23060025_icache_refill.sv
// Instruction-cache line refill engine.
// Issues one line-aligned INCR burst per miss, gathers beats into a line
// buffer, forwards the critical word as its beat arrives, then pulses the
// completed line to the cache. A flush mid-burst drains and drops the rest.
// Ports:
//   clock, reset (async, active low)
//   miss_req_i/miss_addr_i/miss_ready_o      : miss handshake from the icache
//   flush_i                                   : kill the refill in flight
//   crit_valid_o/crit_data_o                  : critical word bypass
//   refill_valid_o/err_o/addr_o/line_o        : completed line for fill
//   inst_paddr_o/psel_o/plen_o/psize_o        : burst request to AXI ctrl
//   inst_prdata_i/pvalid_i/plast_i            : returned read beats
module ysyx_23060025_icache_refill
  import ysyx_23060025_icache_refill_pkg::*;
#(
  parameter int ADDR_LEN   = ICACHE_ADDR_LEN,
  parameter int DATA_LEN   = ICACHE_DATA_LEN,
  parameter int LINE_BEATS = ICACHE_LINE_BEATS
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         miss_req_i,
  input  logic [ADDR_LEN-1:0]          miss_addr_i,
  output logic                         miss_ready_o,
  input  logic                         flush_i,
  output logic                         crit_valid_o,
  output logic [DATA_LEN-1:0]          crit_data_o,
  output logic                         refill_valid_o,
  output logic                         refill_err_o,
  output logic [ADDR_LEN-1:0]          refill_addr_o,
  output logic [LINE_BEATS*DATA_LEN-1:0] refill_line_o,
  output logic [ADDR_LEN-1:0]          inst_paddr_o,
  output logic                         inst_psel_o,
  output logic [7:0]                   inst_plen_o,
  output logic [2:0]                   inst_psize_o,
  input  logic [DATA_LEN-1:0]          inst_prdata_i,
  input  logic                         inst_pvalid_i,
  input  logic                         inst_plast_i
);

  localparam int OFF_W  = $clog2(DATA_LEN / 8);
  localparam int IDX_W  = $clog2(LINE_BEATS);
  localparam int LINE_W = OFF_W + IDX_W;
  localparam logic [IDX_W:0] CNT_FULL = (IDX_W+1)'(LINE_BEATS);
  localparam logic [IDX_W:0] CNT_LAST = (IDX_W+1)'(LINE_BEATS - 1);
  localparam logic [IDX_W:0] CNT_ONE  = (IDX_W+1)'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_LEN-1:0]                 line_addr;
  logic [IDX_W-1:0]                    crit_idx;
  logic [IDX_W:0]                      cnt;
  logic                                kill;
  logic                                err;
  logic [LINE_BEATS-1:0][DATA_LEN-1:0] line_q;

  logic accept, beat, beat_last, cnt_full;
  logic unused_addr;

  assign accept    = (state == IDLE) & miss_req_i;
  assign beat      = (state == BUSY) & inst_pvalid_i;
  assign beat_last = beat & inst_plast_i;
  assign cnt_full  = (cnt == CNT_FULL);

  // Offset bits below the line only feed the critical index.
  assign unused_addr = ^miss_addr_i[LINE_W-1:0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (miss_req_i) state_nxt = BUSY;
      // A burst cannot be cancelled on AXI, so a killed refill waits for
      // the last beat and then skips RESP.
      BUSY:    if (beat_last) state_nxt = (kill | flush_i) ? IDLE : RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      line_addr <= '0;
      crit_idx  <= '0;
      cnt       <= '0;
      kill      <= 1'b0;
      err       <= 1'b0;
      line_q    <= '0;
    end else begin
      if (accept) begin
        line_addr <= {miss_addr_i[ADDR_LEN-1:LINE_W], {LINE_W{1'b0}}};
        crit_idx  <= miss_addr_i[OFF_W +: IDX_W];
        cnt       <= '0;
        kill      <= 1'b0;
        err       <= 1'b0;
      end
      if (state == BUSY) begin
        if (flush_i) kill <= 1'b1;
        if (inst_pvalid_i) begin
          // Overlong bursts saturate the counter and are never written.
          if (!cnt_full) begin
            line_q[cnt[IDX_W-1:0]] <= inst_prdata_i;
            cnt                    <= cnt + CNT_ONE;
          end
          if (inst_plast_i)  err <= err | (cnt != CNT_LAST);
          else if (cnt_full) err <= 1'b1;
        end
      end
    end
  end

  assign miss_ready_o   = (state == IDLE);
  assign inst_psel_o    = (state == BUSY);
  assign inst_paddr_o   = line_addr;
  assign inst_plen_o    = 8'(LINE_BEATS - 1);
  assign inst_psize_o   = axi_size(DATA_LEN);

  assign crit_valid_o   = beat & (cnt == {1'b0, crit_idx}) & ~kill & ~flush_i;
  assign crit_data_o    = inst_prdata_i;

  assign refill_valid_o = (state == RESP) & ~flush_i;
  assign refill_err_o   = (state == RESP) & err;
  assign refill_addr_o  = line_addr;
  assign refill_line_o  = line_q;

endmodule

// File: doc/ysyx_23060025_icache_refill.md
# ysyx_23060025_icache_refill

Line-refill engine between the instruction-cache miss path and the AXI controller's instruction read port (`inst_*`). On a miss it issues one line-aligned INCR burst on `inst_paddr_o/psel_o/plen_o/psize_o` and gathers the returned beats into a line buffer. It forwards the missing (critical) word as soon as its beat arrives, then presents the full line to the cache for fill. A flush arriving mid-burst cannot cancel the AXI transaction, so the block drains the remaining beats and discards them.

## Interface
- ADDR_LEN, 32, address width
- DATA_LEN, 32, beat width; power of two, ≥ 8
- LINE_BEATS, 4, beats per cache line; power of two, ≥ 2
- clock  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low
- miss_req_i  in  1  cache miss request
- miss_addr_i  in  ADDR_LEN  byte address of missing instruction
- miss_ready_o  out  1  request accepted when high with miss_req_i
- flush_i  in  1  fence.i/redirect; kills the current refill
- crit_valid_o  out  1  critical word valid this cycle
- crit_data_o  out  DATA_LEN  critical word
- refill_valid_o  out  1  one-cycle line-complete pulse
- refill_err_o  out  1  qualifies refill_valid_o; burst length mismatch
- refill_addr_o  out  ADDR_LEN  line-aligned address of the line
- refill_line_o  out  LINE_BEATS*DATA_LEN  line data; beat i at bits [i*DATA_LEN +: DATA_LEN]
- inst_paddr_o  out  ADDR_LEN  burst start address
- inst_psel_o  out  1  read request; held until last beat accepted
- inst_plen_o  out  8  LINE_BEATS-1
- inst_psize_o  out  3  log2(DATA_LEN/8)
- inst_prdata_i  in  DATA_LEN  beat data
- inst_pvalid_i  in  1  beat valid
- inst_plast_i  in  1  last beat

## Operation
- Derived constants: OFF_W = log2(DATA_LEN/8), IDX_W = log2(LINE_BEATS). Line address = miss_addr_i with low OFF_W+IDX_W bits zeroed. Critical index = miss_addr_i[OFF_W +: IDX_W].
- States: IDLE, BUSY, RESP.
- IDLE: miss_ready_o=1. On miss_req_i, latch the line address and critical index, clear the beat counter and kill flag, and go to BUSY. flush_i has no effect in IDLE.
- BUSY: inst_psel_o=1, inst_paddr_o=latched line address. Each cycle with inst_pvalid_i:
  - write inst_prdata_i to line buffer slot [counter];
  - increment the counter (IDX_W+1 bits, saturating at LINE_BEATS).
- Critical word: crit_valid_o = BUSY & inst_pvalid_i & counter==critical index & ~kill & ~flush_i. crit_data_o = inst_prdata_i (combinational, same cycle as the beat).
- End of burst: on inst_pvalid_i & inst_plast_i, go to IDLE if kill is set or flush_i is high, else go to RESP.
- Error: error register = (counter at the last beat ≠ LINE_BEATS-1) OR (a non-last beat arrived with counter ≥ LINE_BEATS). Beats with counter ≥ LINE_BEATS are not written.
- flush_i in BUSY sets kill. inst_psel_o stays high until the last beat.
- RESP: refill_valid_o = ~flush_i; refill_err_o = error register. Unconditionally go to IDLE next cycle.
- refill_addr_o and refill_line_o are stable from RESP until the next accepted miss.

## Timing
- Reset (reset=0, asynchronous): state IDLE; counter, kill and error cleared; line buffer, refill_addr_o and inst_paddr_o at 0.
- Output values during reset: miss_ready_o=1, inst_psel_o=0, crit_valid_o=0, refill_valid_o=0, refill_err_o=0, crit_data_o follows inst_prdata_i.
- Reset asserted mid-burst aborts immediately. The AXI controller is reset in the same domain.
- Miss accepted in cycle 0 → inst_psel_o high in cycle 1.
- Last beat in cycle N → refill_valid_o in cycle N+1 → miss_ready_o in cycle N+2.
- No back-to-back miss acceptance: at least one IDLE cycle between refills.
- flush_i in the same cycle as the last beat: result discarded, no RESP.
- flush_i in the RESP cycle: refill_valid_o suppressed.
- inst_pvalid_i in IDLE or RESP: ignored.

## Structure
- Add to ysyx_23060025_define.v: the AXI size encodings (SIZE_4B = 3'b010) and the cache line geometry macros, shared with the icache.
- State encodings are localparams inside the block.
- No sub-module: the line buffer is a register array, the counter is inline.

## Test plan
- Miss 0x3000_0018, beats 0xA0..0xA3 with last on beat 3:
  - inst_paddr_o=0x3000_0010, plen=3, psize=2;
  - crit_valid_o with 0xA2 on the third beat;
  - refill_valid_o with refill_line_o={A3,A2,A1,A0}, refill_err_o=0.
- Slave inserts gaps between beats: line contents are identical and inst_psel_o stays high throughout.
- flush_i after beat 1: remaining beats drained, no crit_valid_o after the flush, no refill_valid_o, miss_ready_o returns after the last beat.
- plast on beat 2: refill_valid_o=1 with refill_err_o=1. Five beats: refill_err_o=1 and the fifth beat is not written.
- Async reset mid-burst: all outputs return to their reset values without a clock edge. The next miss starts cleanly with the counter at 0.
- Miss held high during RESP: accepted only once back in IDLE (cycle N+2).
